// File: rtl/gcn_pkg.sv
// Shared types and constants for the GCN feature x weight transform scheduler.
package gcn_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    READ_F = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic [12:0] FEATURE_BASE_ADDR = 13'h200;

endpackage

// File: rtl/gcn_tag_pipe.sv
// Delay line carrying {valid,row,col} result tags from the MAC strobe to the
// result-buffer write strobe.
module gcn_tag_pipe #(
  parameter int DEPTH = 1,
  parameter int ROW_W = 3,
  parameter int COL_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [ROW_W-1:0] row_i,
  input  logic [COL_W-1:0] col_i,
  output logic             valid_o,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o
);

  localparam int TAG_W = 1 + ROW_W + COL_W;

  logic [TAG_W-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= {valid_i, row_i, col_i};
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign {valid_o, row_o, col_o} = pipe_q[DEPTH-1];

endmodule

// File: rtl/gcn_transform_scheduler.sv
// Walks every (weight column, feature row) pair, drives the memory read port
// and the dot-product strobes, and tags results for the FM x WM buffer.
module gcn_transform_scheduler
  import gcn_pkg::*;
#(
  parameter int FEATURE_ROWS          = 6,
  parameter int WEIGHT_COLS           = 3,
  parameter int ADDRESS_WIDTH         = 13,
  parameter int DOT_LATENCY           = 1,
  parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS),
  parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             stall,
  output logic [ADDRESS_WIDTH-1:0]         read_address,
  output logic                             enable_read,
  output logic                             load_weight,
  output logic                             mac_valid,
  output logic                             write_enable,
  output logic [COUNTER_FEATURE_WIDTH-1:0] write_row,
  output logic [COUNTER_WEIGHT_WIDTH-1:0]  write_col,
  output logic                             done
);

  localparam int DRAIN_W = $clog2(DOT_LATENCY + 1);
  localparam logic [COUNTER_FEATURE_WIDTH-1:0] F_LAST = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);
  localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  W_LAST = COUNTER_WEIGHT_WIDTH'(WEIGHT_COLS - 1);
  localparam logic [DRAIN_W-1:0]               D_LAST = DRAIN_W'(DOT_LATENCY - 1);
  localparam logic [ADDRESS_WIDTH-1:0]         BASE   = ADDRESS_WIDTH'(FEATURE_BASE_ADDR);

  state_e                             state_q;
  logic [COUNTER_WEIGHT_WIDTH-1:0]    w_q;
  logic [COUNTER_FEATURE_WIDTH-1:0]   f_q;
  logic [DRAIN_W-1:0]                 drain_q;
  logic [ADDRESS_WIDTH-1:0]           addr_q;
  logic                               rd_q;
  logic                               ld_q;
  logic                               mac_q;
  logic                               done_q;

  // Output registers are loaded together with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      w_q     <= '0;
      f_q     <= '0;
      drain_q <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      ld_q    <= 1'b0;
      mac_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD_W;
            w_q     <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b1;
            ld_q    <= 1'b1;
            mac_q   <= 1'b0;
          end
        end
        LOAD_W: begin
          if (!stall) begin
            state_q <= READ_F;
            f_q     <= '0;
            addr_q  <= BASE;
            ld_q    <= 1'b0;
            mac_q   <= 1'b1;
          end
        end
        READ_F: begin
          if (!stall) begin
            if (f_q < F_LAST) begin
              f_q    <= f_q + COUNTER_FEATURE_WIDTH'(1);
              addr_q <= BASE + ADDRESS_WIDTH'(f_q) + ADDRESS_WIDTH'(1);
            end else if (w_q < W_LAST) begin
              state_q <= LOAD_W;
              w_q     <= w_q + COUNTER_WEIGHT_WIDTH'(1);
              addr_q  <= ADDRESS_WIDTH'(w_q) + ADDRESS_WIDTH'(1);
              ld_q    <= 1'b1;
              mac_q   <= 1'b0;
            end else begin
              state_q <= DRAIN;
              drain_q <= '0;
              addr_q  <= '0;
              rd_q    <= 1'b0;
              mac_q   <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (drain_q == D_LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + DRAIN_W'(1);
          end
        end
        DONE: begin
          if (!start) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          addr_q  <= '0;
          rd_q    <= 1'b0;
          ld_q    <= 1'b0;
          mac_q   <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Strobes are only ever set in LOAD_W/READ_F, so gating by stall here is
  // exactly "stall matters in the issue states only".
  assign read_address = addr_q;
  assign enable_read  = rd_q & ~stall;
  assign load_weight  = ld_q & ~stall;
  assign mac_valid    = mac_q & ~stall;
  assign done         = done_q;

  gcn_tag_pipe #(
    .DEPTH (DOT_LATENCY),
    .ROW_W (COUNTER_FEATURE_WIDTH),
    .COL_W (COUNTER_WEIGHT_WIDTH)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .valid_i (mac_valid),
    .row_i   (mac_valid ? f_q : '0),
    .col_i   (mac_valid ? w_q : '0),
    .valid_o (write_enable),
    .row_o   (write_row),
    .col_o   (write_col)
  );

endmodule

// File: tb/tb_gcn_transform_scheduler.sv
// Directed bench: two schedulers (DOT_LATENCY 1 and 3) share stimulus and are
// checked cycle by cycle against timing derived from the schedule formulas.
module tb_gcn_transform_scheduler;

  localparam int FR        = 6;
  localparam int WC        = 3;
  localparam int PERIOD    = FR + 1;
  localparam int LAST_ISS  = WC * PERIOD - 1;

  typedef struct packed {
    logic [12:0] addr;
    logic        rd;
    logic        ld;
    logic        mac;
    logic        we;
    logic [2:0]  row;
    logic [1:0]  col;
    logic        dn;
  } exp_t;

  typedef struct {
    logic rst;
    logic st;
    logic sl;
    exp_t e1;
    exp_t e3;
  } vec_t;

  logic clk = 1'b0;
  logic reset, start, stall;

  logic [12:0] a1, a3;
  logic        rd1, ld1, mac1, we1, dn1, rd3, ld3, mac3, we3, dn3;
  logic [2:0]  row1, row3;
  logic [1:0]  col1, col3;

  exp_t obs1, obs3;
  assign obs1 = {a1, rd1, ld1, mac1, we1, row1, col1, dn1};
  assign obs3 = {a3, rd3, ld3, mac3, we3, row3, col3, dn3};

  int n_tests = 0;
  int n_fail  = 0;
  vec_t tbl [31];

  always #5 clk = ~clk;

  gcn_transform_scheduler #(.DOT_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .read_address(a1), .enable_read(rd1), .load_weight(ld1), .mac_valid(mac1),
    .write_enable(we1), .write_row(row1), .write_col(col1), .done(dn1)
  );

  gcn_transform_scheduler #(.DOT_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .read_address(a3), .enable_read(rd3), .load_weight(ld3), .mac_valid(mac3),
    .write_enable(we3), .write_row(row3), .write_col(col3), .done(dn3)
  );

  // Read-side expectation for pass cycle c with a stall of n cycles at s.
  function automatic exp_t issue_at(int c, int s, int n);
    exp_t e;
    int   cr, k, r;
    bit   stalled;
    e = '0;
    if (c < 0) return e;
    stalled = (c >= s) && (c < s + n);
    if (c < s) cr = c;
    else if (stalled) cr = s;
    else cr = c - n;
    if (cr > LAST_ISS) return e;
    k = cr / PERIOD;
    r = cr % PERIOD;
    if (r == 0) e.addr = 13'(k);
    else e.addr = 13'h200 + 13'(r - 1);
    if (!stalled) begin
      e.rd  = 1'b1;
      e.ld  = (r == 0);
      e.mac = (r != 0);
    end
    if (r != 0) begin
      e.row = 3'(r - 1);
      e.col = 2'(k);
    end
    return e;
  endfunction

  function automatic exp_t expect_at(int c, int s, int n, int lat, int drop);
    exp_t e, w;
    if (c < 0 || c > drop) return '0;
    e     = issue_at(c, s, n);
    w     = issue_at(c - lat, s, n);
    e.we  = w.mac;
    e.row = w.mac ? w.row : 3'd0;
    e.col = w.mac ? w.col : 2'd0;
    e.dn  = (c - n) >= (LAST_ISS + 1 + lat);
    return e;
  endfunction

  task automatic check(input exp_t got, input exp_t exp, input string tag);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got addr=%h rd=%b ld=%b mac=%b we=%b row=%0d col=%0d done=%b, expected addr=%h rd=%b ld=%b mac=%b we=%b row=%0d col=%0d done=%b",
               tag, got.addr, got.rd, got.ld, got.mac, got.we, got.row, got.col, got.dn,
               exp.addr, exp.rd, exp.ld, exp.mac, exp.we, exp.row, exp.col, exp.dn);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    reset = v.rst;
    start = v.st;
    stall = v.sl;
    @(negedge clk);
    check(obs1, v.e1, {tag, "/lat1"});
    check(obs3, v.e3, {tag, "/lat3"});
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;

    // Main pass: index 0 reset, 1 idle, 2 start (cycle -1), 3.. cycles 0..27.
    // Stall is held during DRAIN/DONE (cycles 21..25) and must be ignored;
    // start is held through DONE and dropped at cycle 26.
    tbl[0] = '{rst: 1'b1, st: 1'b0, sl: 1'b0, e1: '0, e3: '0};
    tbl[1] = '{rst: 1'b0, st: 1'b0, sl: 1'b0, e1: '0, e3: '0};
    tbl[2] = '{rst: 1'b0, st: 1'b1, sl: 1'b0, e1: '0, e3: '0};
    for (int i = 3; i < 31; i++) begin
      int c;
      c = i - 3;
      tbl[i].rst = 1'b0;
      tbl[i].st  = (c <= 25);
      tbl[i].sl  = (c >= 21) && (c <= 25);
      tbl[i].e1  = expect_at(c, 0, 0, 1, 26);
      tbl[i].e3  = expect_at(c, 0, 0, 3, 26);
    end

    reset = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 31; i++) apply(tbl[i], $sformatf("pass1[%0d]", i));
    for (int i = 1; i < 31; i++) apply(tbl[i], $sformatf("pass2[%0d]", i));

    // Stall for 3 cycles while issuing row 3 of column 0.
    v = '{rst: 1'b0, st: 1'b1, sl: 1'b0, e1: '0, e3: '0};
    apply(v, "stall_start");
    for (int c = 0; c <= 30; c++) begin
      v.rst = 1'b0;
      v.st  = (c <= 28);
      v.sl  = (c >= 4) && (c <= 6);
      v.e1  = expect_at(c, 4, 3, 1, 29);
      v.e3  = expect_at(c, 4, 3, 3, 29);
      apply(v, $sformatf("stall_c%0d", c));
    end

    // Reset in cycle 10 aborts the pass and discards in-flight tags.
    v = '{rst: 1'b0, st: 1'b1, sl: 1'b0, e1: '0, e3: '0};
    apply(v, "rst_start");
    for (int c = 0; c <= 13; c++) begin
      v.rst = (c == 10);
      v.st  = (c < 10);
      v.sl  = 1'b0;
      v.e1  = (c <= 10) ? expect_at(c, 0, 0, 1, 99) : exp_t'('0);
      v.e3  = (c <= 10) ? expect_at(c, 0, 0, 3, 99) : exp_t'('0);
      apply(v, $sformatf("midrst_c%0d", c));
    end
    for (int i = 2; i < 31; i++) apply(tbl[i], $sformatf("restart[%0d]", i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
